// File: rtl/rr_priority_encoder.sv
// Registered priority encoder with fixed (highest index) and round-robin modes.
// Round-robin pointer names the highest-priority index and walks downward.
module rr_priority_encoder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] d_in,
  output logic [W-1:0] d_out,
  output logic         valid,
  output logic [N-1:0] grant
);

  logic [W-1:0] ptr;
  logic [N-1:0] lo_mask;
  logic [N-1:0] lo_req;
  logic [W-1:0] fp_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] sel_idx;
  logic [W-1:0] ptr_nxt;
  logic [N-1:0] sel_onehot;
  logic         hit;

  function automatic logic [W-1:0] msb_idx(input logic [N-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) msb_idx = W'(i);
    end
  endfunction

  // Round-robin order ptr..0 then N-1..ptr+1 equals: highest request at or
  // below ptr if any, otherwise the highest request overall.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = (W'(i) <= ptr);
    end
  end

  assign lo_req = d_in & lo_mask;
  assign hit    = |d_in;
  assign fp_idx = msb_idx(d_in);
  assign rr_idx = (|lo_req) ? msb_idx(lo_req) : fp_idx;

  always_comb begin
    sel_idx = fp_idx;
    unique case (1'b1)
      mode:  sel_idx = rr_idx;
      !mode: sel_idx = fp_idx;
    endcase
  end

  assign ptr_nxt = (sel_idx == '0) ? W'(N - 1)
                                   : sel_idx - W'(1);
  assign sel_onehot = N'(1) << sel_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
      valid <= 1'b0;
      grant <= '0;
      ptr   <= W'(N - 1);
    end else if (en) begin
      if (hit) begin
        d_out <= sel_idx;
        valid <= 1'b1;
        grant <= sel_onehot;
        if (mode) ptr <= ptr_nxt;
      end else begin
        d_out <= '0;
        valid <= 1'b0;
        grant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Randomized + directed bench for rr_priority_encoder (N=8 and N=5).
// Reference model walks the search order with modular arithmetic.
module tb_rr_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [7:0] d8;
  logic [4:0] d5;
  logic [2:0] q8;
  logic       v8;
  logic [7:0] g8;
  logic [2:0] q5;
  logic       v5;
  logic [4:0] g5;

  int checks = 0;
  int failures = 0;

  int mq8, mv8, mp8;
  int mq5, mv5, mp5;

  always #5 clk = ~clk;

  rr_priority_encoder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .d_in(d8), .d_out(q8), .valid(v8), .grant(g8)
  );

  rr_priority_encoder #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .d_in(d5), .d_out(q5), .valid(v5), .grant(g5)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input int n, input int p,
                              input bit m, input logic [7:0] d);
    int idx;
    if (!m) begin
      for (int i = n - 1; i >= 0; i--)
        if (d[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) begin
        idx = (p - k + n) % n;
        if (d[idx]) return idx;
      end
    end
    return -1;
  endfunction

  task automatic model(input int n, input bit r, input bit e,
                       input bit m, input logic [7:0] d,
                       inout int q, inout int v, inout int p);
    int g;
    if (r) begin
      q = 0; v = 0; p = n - 1;
    end else if (e) begin
      g = pick(n, p, m, d);
      if (g < 0) begin
        q = 0; v = 0;
      end else begin
        q = g; v = 1;
        if (m) p = (g == 0) ? n - 1 : g - 1;
      end
    end
  endtask

  // One clock: drive, advance model, compare; e8/e5 >= 0 add a fixed check.
  task automatic step(input bit r, input bit e, input bit m,
                      input logic [7:0] a, input logic [4:0] b,
                      input int e8, input int e5);
    rst = r; en = e; mode = m; d8 = a; d5 = b;
    @(posedge clk);
    model(8, r, e, m, a, mq8, mv8, mp8);
    model(5, r, e, m, {3'b000, b}, mq5, mv5, mp5);
    #1;
    check("d_out8", int'(q8), mq8);
    check("valid8", int'(v8), mv8);
    check("grant8", int'(g8), mv8 ? (1 << mq8) : 0);
    check("d_out5", int'(q5), mq5);
    check("valid5", int'(v5), mv5);
    check("grant5", int'(g5), mv5 ? (1 << mq5) : 0);
    if (e8 >= 0) check("dir8", int'(q8), e8);
    if (e5 >= 0) check("dir5", int'(q5), e5);
  endtask

  initial begin
    logic [7:0] ra;
    logic [4:0] rb;
    mq8 = 0; mv8 = 0; mp8 = 7;
    mq5 = 0; mv5 = 0; mp5 = 4;
    rst = 1'b1; en = 1'b1; mode = 1'b1; d8 = 8'hFF; d5 = 5'h1F;

    step(1, 1, 1, 8'hFF, 5'h1F, 0, 0);
    step(1, 1, 1, 8'hFF, 5'h1F, 0, 0);
    check("rst_valid", int'(v8), 0);
    check("rst_grant", int'(g8), 0);
    step(0, 1, 1, 8'hFF, 5'h00, 7, 0);

    step(1, 1, 0, 8'h00, 5'h00, 0, 0);
    step(0, 1, 0, 8'b11001100, 5'h00, 7, -1);
    check("fp_g0", int'(g8), 8'h80);
    step(0, 1, 0, 8'b00110011, 5'h00, 5, -1);
    check("fp_g1", int'(g8), 8'h20);
    step(0, 1, 0, 8'b00000100, 5'h00, 2, -1);
    check("fp_g2", int'(g8), 8'h04);
    step(0, 1, 0, 8'b00000000, 5'h00, 0, -1);
    check("fp_v3", int'(v8), 0);
    check("fp_g3", int'(g8), 0);

    step(1, 1, 1, 8'h00, 5'h00, 0, 0);
    step(0, 1, 1, 8'b10010010, 5'b10001, 7, 4);
    step(0, 1, 1, 8'b10010010, 5'b10001, 4, 0);
    step(0, 1, 1, 8'b10010010, 5'b10001, 1, 4);
    step(0, 1, 1, 8'b10010010, 5'b00000, 7, 0);

    step(1, 1, 1, 8'h00, 5'h00, 0, 0);
    step(0, 1, 1, 8'b00000001, 5'h00, 0, -1);
    step(0, 1, 1, 8'b10000001, 5'h00, 7, -1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'hFF, 5'h1F, 7, -1);
      check("hold_v", int'(v8), 1);
    end
    step(0, 0, 0, 8'h00, 5'h00, 7, -1);

    step(1, 1, 1, 8'h00, 5'h00, 0, 0);
    step(0, 1, 1, 8'b00010000, 5'h00, 4, -1);
    step(0, 1, 0, 8'b00011000, 5'h00, 4, -1);
    step(0, 1, 1, 8'b00011000, 5'h00, 3, -1);

    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 5'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        ra = ra & 8'($urandom);
        rb = rb & 5'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        ra = 8'h00;
        rb = 5'h00;
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
           1'($urandom), ra, rb, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
RR_PRIORITY_ENCODER -- requirements
Module: rr_priority_encoder

Interface
REQ-001 Parameter: N, default 8, request width; N SHALL be >= 2 and need not be a power of two.
REQ-002 Parameter: W, default $clog2(N), index width; W SHALL NOT be overridden independently of N.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  sample enable; when 0, all state and outputs SHALL hold.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 d_in  input  N  request vector; bit i = request i.
REQ-008 d_out  output  W  registered index of the granted request.
REQ-009 valid  output  1  registered; 1 = d_out/grant hold a real grant.
REQ-010 grant  output  N  registered one-hot grant; bit d_out set when valid=1.

Function
REQ-011 Latency SHALL be 1 cycle: d_in sampled at edge k with en=1 appears on d_out/valid/grant after edge k.
REQ-012 Internal pointer ptr (W bits, range 0..N-1) SHALL be the highest-priority index in round-robin mode.
REQ-013 Fixed mode (mode=0): the grant SHALL go to the highest set index of d_in; ptr SHALL hold.
REQ-014 Round-robin (mode=1): search order SHALL be ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
REQ-015 After a round-robin grant to index g: ptr <= g-1 if g>0, else N-1 (wrap).
REQ-016 d_in=0 with en=1: valid<=0, d_out<=0, grant<=0, ptr holds (any mode).
REQ-017 en=0: d_out, valid, grant and ptr SHALL all hold, regardless of d_in or mode.
REQ-018 A change of mode SHALL take effect on the next en=1 edge, with no reset of ptr.
REQ-019 The invariant valid=0 => grant=0 and d_out=0 SHALL hold in every cycle.
REQ-020 grant SHALL always be zero or one-hot and consistent with d_out.
REQ-021 Non-power-of-two N: ptr SHALL never take values >= N; wrap SHALL go from 0 to N-1.
REQ-022 The block SHALL be fully synchronous and free of latches and combinational loops from d_in to outputs.

Reset
REQ-023 On any edge with rst=1: d_out<=0, valid<=0, grant<=0, ptr<=N-1.
REQ-024 rst SHALL take priority over en, mode and d_in.
REQ-025 Reset asserted mid-stream SHALL discard any pending request; the first grant after reset SHALL follow fixed-priority order, from ptr=N-1.

Verification (N=8 unless stated)
REQ-026 rst=1 for 2 cycles with d_in=8'hFF, en=1 -> d_out=0, valid=0, grant=0; the first round-robin grant after release is index 7.
REQ-027 mode=0, en=1, d_in sequence 8'b11001100, 8'b00110011, 8'b00000100, 8'b00000000 -> next-cycle d_out=7,5,2,0; valid=1,1,1,0; grant=8'h80,8'h20,8'h04,8'h00.
REQ-028 mode=1, d_in=8'b10010010 held for 4 cycles from reset -> d_out=7,4,1,7 (ptr wraps).
REQ-029 mode=1, d_in=8'b00000001 then 8'b10000001 -> d_out=0 then 7 (ptr wrapped 0->7); then en=0 with d_in=8'hFF for 3 cycles -> outputs hold at 7, valid=1.
REQ-030 mode=1, grant index 4 (ptr=3), then switch to mode=0 with d_in=8'b00011000 -> d_out=4; switch back to mode=1 with the same d_in -> d_out=3 (ptr preserved).
REQ-031 N=5, mode=1, d_in=5'b10001 for 3 cycles -> d_out=4,0,4; ptr never exceeds 4.
